// File: rtl/wb_sched.sv
// Writeback scheduler: round-robin arbiter over NREQ writeback requesters feeding one
// register-file write port, plus a 31-entry busy scoreboard for long-latency destinations.
// Latency: grant -> registered write 1 cycle. Backpressure: one requester granted per cycle.
module wb_sched #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [5*NREQ-1:0]  req_reg,
  input  logic [32*NREQ-1:0] req_data,
  output logic               wen,
  output logic [4:0]         wreg,
  output logic [31:0]        wdata,
  input  logic               iss_valid,
  input  logic [4:0]         iss_rd,
  output logic               iss_ready,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  output logic               busy1,
  output logic               busy2
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [31:0]      sb_q, sb_d;
  logic             wen_q, wen_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [4:0]       gnt_reg;
  logic [31:0]      gnt_data;

  logic [4:0]  reg_a  [NREQ];
  logic [31:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign reg_a[g]  = req_reg[g*5 +: 5];
    assign data_a[g] = req_data[g*32 +: 32];
  end

  assign gnt_reg  = reg_a[gnt_idx];
  assign gnt_data = data_a[gnt_idx];

  // Round-robin search starting at ptr; the first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[(int'(ptr_q) + i) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'((int'(ptr_q) + i) % NREQ);
      end
    end
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Scoreboard lookups are pure reads of the busy bits; x0 is hardwired clear.
  always_comb begin
    iss_ready = ~sb_q[iss_rd];
    busy1     = sb_q[rs1];
    busy2     = sb_q[rs2];
  end

  // Next state: pointer advance, scoreboard clear/set, registered write port.
  always_comb begin
    ptr_d   = ptr_q;
    sb_d    = sb_q;
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (gnt_any) begin
      ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      wen_d   = (gnt_reg != 5'd0);
      wreg_d  = gnt_reg;
      wdata_d = gnt_data;
      sb_d[gnt_reg] = 1'b0;
    end
    // Set after clear: a new claim on a register being written back by a
    // short-latency op must stay pending for the long-latency result.
    if (iss_valid && iss_ready) begin
      sb_d[iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset that discards any in-flight grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      sb_q    <= '0;
      wen_q   <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      sb_q    <= sb_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign wreg  = wreg_q;
  assign wdata = wdata_q;

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 Parameters: NREQ, 3, number of writeback requesters; port index 0..NREQ-1.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  NREQ  requester i holds a writeback.
REQ-005 req_ready  output  NREQ  grant to requester i; transfer when valid&ready.
REQ-006 req_reg  input  5*NREQ  destination register of requester i.
REQ-007 req_data  input  32*NREQ  write data of requester i.
REQ-008 wen  output  1  registered write enable to register file.
REQ-009 wreg  output  5  registered write register.
REQ-010 wdata  output  32  registered write data.
REQ-011 iss_valid  input  1  issue of a long-latency op claiming iss_rd.
REQ-012 iss_rd  input  5  destination claimed by the issue.
REQ-013 iss_ready  output  1  issue accepted this cycle.
REQ-014 rs1, rs2  input  5 each  source registers queried by decode.
REQ-015 busy1, busy2  output  1 each  source has a pending write.

Function
REQ-016 Scoreboard: 31 busy bits for x1..x31; x0 never busy.
REQ-017 iss_ready = ~sb[iss_rd], combinational; iss_ready=1 when iss_rd=0.
REQ-018 On iss_valid&iss_ready with iss_rd!=0, sb[iss_rd] set at next edge; iss_rd=0 sets nothing.
REQ-019 busy1 = sb[rs1], busy2 = sb[rs2], combinational, no other terms; rs=0 gives 0.
REQ-020 Arbiter: round-robin over NREQ, priority pointer ptr (0..NREQ-1); search order ptr, ptr+1, ... modulo NREQ.
REQ-021 req_ready is one-hot or zero; asserted only for the first valid requester in search order; combinational from req_valid and ptr.
REQ-022 On grant to k, ptr <= (k+1) mod NREQ at next edge; no grant leaves ptr unchanged.
REQ-023 Grant to k: next cycle wen=(req_reg[k]!=0), wreg=req_reg[k], wdata=req_data[k]; latency exactly 1 cycle.
REQ-024 No grant: next cycle wen=0; wreg/wdata hold previous values.
REQ-025 Grant to k with req_reg[k]!=0 clears sb[req_reg[k]] at next edge; busy visible through grant cycle, deasserted on the wen cycle (register-file passthrough supplies data).
REQ-026 Grant to a register not marked busy (short-latency writeback) allowed; clear is a no-op.
REQ-027 Same-cycle issue set and grant clear of one register cannot occur (iss_ready=0 while busy); set and clear of different registers both take effect.
REQ-028 Requesters hold valid, reg, data stable until granted; no throughput limit: one grant per cycle sustained.

Reset
REQ-029 reset_n=0 at an edge: sb all clear, ptr=0, wen=0, wreg=0, wdata=0.
REQ-030 Reset overrides same-cycle grants and issues; in-flight grant discarded, no write after reset.
REQ-031 During reset, req_ready and iss_ready still follow REQ-017/REQ-021 combinationally; state remains cleared.

Verification
REQ-032 Issue rd=5; next cycle rs1=5 -> busy1=1, iss_rd=5 -> iss_ready=0; req1 valid reg=5 data=0xDEADBEEF -> ready1=1, next cycle wen=1 wreg=5 wdata=0xDEADBEEF busy1=0.
REQ-033 All three valid continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles, wen=1 every cycle after the first.
REQ-034 ptr=1, only req0 and req2 valid -> req2 granted, then ptr=0, req0 granted next.
REQ-035 Grant with req_reg=0, data 0x12345678 -> next cycle wen=0, wreg=0; scoreboard unchanged.
REQ-036 Issue rd=7 and rd=9 pending, reset_n=0 one cycle during grant of reg 7 -> after reset busy for 7 and 9 = 0, wen=0, ptr=0.
REQ-037 Issue rd=3 same cycle as grant to reg 3 -> iss_ready=0; next cycle sb[3]=0, iss_ready=1 for rd=3.
